// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared APB state encodings and default bus widths
package apb_pkg;

  localparam int APB_ADDR_W = 8;
  localparam int APB_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } apb_state_e;

endpackage

// File: rtl/apb_mem_array.sv
// rtl/apb_mem_array.sv - byte memory, async clear, sync write, combinational read
module apb_mem_array #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256,
  parameter int AW     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem[k] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/apb_mem_completer.sv
// rtl/apb_mem_completer.sv - APB completer with wait states backed by apb_mem_array
module apb_mem_completer
  import apb_pkg::*;
#(
  parameter int ADDR_W      = APB_ADDR_W,
  parameter int DATA_W      = APB_DATA_W,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr,
  output logic [1:0]        stage
);

  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so DEPTH == 2**ADDR_W is representable in the range check.
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

  apb_state_e        state;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              wr_q;
  logic              in_range;
  logic              complete;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  assign in_range = ({1'b0, addr_q} < DEPTH_LIM);
  assign complete = (state == ACCESS) && psel && (cnt == 4'd0);
  assign mem_we   = complete && in_range && wr_q;
  assign stage    = state;

  apb_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (MEM_AW)
  ) u_mem (
    .clk   (pclk),
    .rst_n (presetn),
    .we    (mem_we),
    .waddr (addr_q[MEM_AW-1:0]),
    .wdata (wdata_q),
    .raddr (addr_q[MEM_AW-1:0]),
    .rdata (mem_rdata)
  );

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      prdata  <= '0;
      pready  <= 1'b0;
      pslverr <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (psel && !penable) begin
            addr_q  <= paddr;
            wdata_q <= pwdata;
            wr_q    <= pwrite;
            cnt     <= 4'(WAIT_CYCLES);
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          // Dropping psel aborts even when the wait count has just expired.
          if (!psel) begin
            state <= IDLE;
          end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            pready <= 1'b1;
            if (!in_range) begin
              pslverr <= 1'b1;
            end else if (!wr_q) begin
              prdata <= mem_rdata;
            end
            state <= RESP;
          end
        end
        RESP: begin
          pready  <= 1'b0;
          pslverr <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_mem_completer.sv
// tb/tb_apb_mem_completer.sv - self-checking bench for apb_mem_completer
module tb_apb_mem_completer;

  logic       pclk = 1'b0;
  logic       presetn;
  logic       psel    [3];
  logic       penable [3];
  logic       pwrite  [3];
  logic [7:0] paddr   [3];
  logic [7:0] pwdata  [3];
  logic [7:0] prdata  [3];
  logic       pready  [3];
  logic       pslverr [3];
  logic [1:0] stage   [3];

  int         tests = 0;
  int         fails = 0;

  int         depth_m [3] = '{256, 128, 128};
  int         wait_m  [3] = '{0, 3, 2};
  logic [7:0] mem_m   [3][256];
  logic [7:0] rd_m    [3];

  always #5 pclk = ~pclk;

  apb_mem_completer #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .WAIT_CYCLES(0)) u0 (
    .pclk(pclk), .presetn(presetn), .psel(psel[0]), .penable(penable[0]),
    .pwrite(pwrite[0]), .paddr(paddr[0]), .pwdata(pwdata[0]), .prdata(prdata[0]),
    .pready(pready[0]), .pslverr(pslverr[0]), .stage(stage[0]));

  apb_mem_completer #(.ADDR_W(8), .DATA_W(8), .DEPTH(128), .WAIT_CYCLES(3)) u1 (
    .pclk(pclk), .presetn(presetn), .psel(psel[1]), .penable(penable[1]),
    .pwrite(pwrite[1]), .paddr(paddr[1]), .pwdata(pwdata[1]), .prdata(prdata[1]),
    .pready(pready[1]), .pslverr(pslverr[1]), .stage(stage[1]));

  apb_mem_completer #(.ADDR_W(8), .DATA_W(8), .DEPTH(128), .WAIT_CYCLES(2)) u2 (
    .pclk(pclk), .presetn(presetn), .psel(psel[2]), .penable(penable[2]),
    .pwrite(pwrite[2]), .paddr(paddr[2]), .pwdata(pwdata[2]), .prdata(prdata[2]),
    .pready(pready[2]), .pslverr(pslverr[2]), .stage(stage[2]));

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin
      rd_m[i] = 8'h00;
      for (int a = 0; a < 256; a++) mem_m[i][a] = 8'h00;
    end
  endtask

  // Reference behaviour of one completed transfer: error flag and expected prdata afterwards.
  task automatic model_xfer(input int i, input bit wr, input logic [7:0] a, input logic [7:0] d,
                            output logic exp_err, output logic [7:0] exp_rd);
    exp_err = (int'(a) >= depth_m[i]);
    if (!exp_err) begin
      if (wr) mem_m[i][a] = d;
      else    rd_m[i] = mem_m[i][a];
    end
    exp_rd = rd_m[i];
  endtask

  // Caller is at a negedge. Drives one full transfer; lat is the cycle of pready (setup = 0).
  // Returns at the negedge after the pready cycle, i.e. the first cycle a new setup may use.
  task automatic xfer(input int i, input bit wr, input logic [7:0] a, input logic [7:0] d,
                      output int lat, output logic err, output logic [7:0] rd,
                      output logic rdy_after);
    lat = -1; err = 1'bx; rd = 8'hxx;
    psel[i] = 1'b1; penable[i] = 1'b0; pwrite[i] = wr; paddr[i] = a; pwdata[i] = d;
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      @(negedge pclk);
      penable[i] = 1'b1;
      if (pready[i] === 1'b1) begin
        lat = c; err = pslverr[i]; rd = prdata[i];
      end
    end
    psel[i] = 1'b0; penable[i] = 1'b0;
    @(negedge pclk);
    rdy_after = pready[i];
  endtask

  task automatic test_reset();
    presetn = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      tests++;
      if ({prdata[i], pready[i], pslverr[i], stage[i]} !== 12'h000) begin
        fails++;
        $display("FAIL reset_state[%0d]: got prdata=%h pready=%b pslverr=%b stage=%b, want all zero",
                 i, prdata[i], pready[i], pslverr[i], stage[i]);
      end
    end
    model_clear();
    @(negedge pclk);
    presetn = 1'b1;
    @(negedge pclk);
  endtask

  task automatic test_write_read();
    int lat; logic err, ra, ee; logic [7:0] rd, er;
    xfer(0, 1'b1, 8'h10, 8'hA5, lat, err, rd, ra);
    model_xfer(0, 1'b1, 8'h10, 8'hA5, ee, er);
    tests++;
    if (lat !== 2 || err !== 1'b0 || ra !== 1'b0) begin
      fails++;
      $display("FAIL wr_basic: got lat=%0d err=%b ready_next=%b, want lat=2 err=0 ready_next=0", lat, err, ra);
    end
    @(negedge pclk);
    xfer(0, 1'b0, 8'h10, 8'h00, lat, err, rd, ra);
    model_xfer(0, 1'b0, 8'h10, 8'h00, ee, er);
    tests++;
    if (lat !== 2 || rd !== 8'hA5 || err !== 1'b0) begin
      fails++;
      $display("FAIL rd_basic: got lat=%0d prdata=%h err=%b, want lat=2 prdata=a5 err=0", lat, rd, err);
    end
  endtask

  task automatic test_wait_states();
    int lat; logic err, ra, ee; logic [7:0] rd, er;
    xfer(1, 1'b1, 8'h10, 8'hA5, lat, err, rd, ra);
    model_xfer(1, 1'b1, 8'h10, 8'hA5, ee, er);
    tests++;
    if (lat !== 5 || err !== 1'b0) begin
      fails++;
      $display("FAIL wait_wr: got lat=%0d err=%b, want lat=5 err=0", lat, err);
    end
    xfer(1, 1'b0, 8'h10, 8'h00, lat, err, rd, ra);
    model_xfer(1, 1'b0, 8'h10, 8'h00, ee, er);
    tests++;
    if (lat !== 5 || rd !== 8'hA5 || ra !== 1'b0) begin
      fails++;
      $display("FAIL wait_rd: got lat=%0d prdata=%h ready_next=%b, want lat=5 prdata=a5 ready_next=0", lat, rd, ra);
    end
  endtask

  task automatic test_out_of_range();
    int lat; logic err, ra, ee; logic [7:0] rd, er;
    xfer(1, 1'b1, 8'h80, 8'h3C, lat, err, rd, ra);
    model_xfer(1, 1'b1, 8'h80, 8'h3C, ee, er);
    tests++;
    if (lat !== 5 || err !== 1'b1 || rd !== er) begin
      fails++;
      $display("FAIL oor_wr: got lat=%0d err=%b prdata=%h, want lat=5 err=1 prdata=%h", lat, err, rd, er);
    end
    xfer(1, 1'b0, 8'hFF, 8'h00, lat, err, rd, ra);
    model_xfer(1, 1'b0, 8'hFF, 8'h00, ee, er);
    tests++;
    if (err !== 1'b1 || rd !== er) begin
      fails++;
      $display("FAIL oor_rd: got err=%b prdata=%h, want err=1 prdata=%h", err, rd, er);
    end
    xfer(1, 1'b0, 8'h00, 8'h00, lat, err, rd, ra);
    model_xfer(1, 1'b0, 8'h00, 8'h00, ee, er);
    tests++;
    if (err !== 1'b0 || rd !== 8'h00) begin
      fails++;
      $display("FAIL oor_rd0: got err=%b prdata=%h, want err=0 prdata=00", err, rd);
    end
  endtask

  // Drops psel during ACCESS at the given cycle and checks that nothing completes.
  task automatic abort_case(input logic [7:0] a, input logic [7:0] d, input int drop_cycle, input string nm);
    int lat; logic err, ra, ee, seen; logic [7:0] rd, er;
    seen = 1'b0;
    psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1; paddr[2] = a; pwdata[2] = d;
    for (int c = 1; c <= 8; c++) begin
      @(negedge pclk);
      if (pready[2] === 1'b1) seen = 1'b1;
      penable[2] = 1'b1;
      if (c >= drop_cycle) begin psel[2] = 1'b0; penable[2] = 1'b0; end
    end
    tests++;
    if (seen !== 1'b0 || stage[2] !== 2'b00) begin
      fails++;
      $display("FAIL %s: got pready_seen=%b stage=%b, want pready_seen=0 stage=00", nm, seen, stage[2]);
    end
    xfer(2, 1'b0, a, 8'h00, lat, err, rd, ra);
    model_xfer(2, 1'b0, a, 8'h00, ee, er);
    tests++;
    if (lat !== 4 || rd !== er) begin
      fails++;
      $display("FAIL %s_rd: got lat=%0d prdata=%h, want lat=4 prdata=%h", nm, lat, rd, er);
    end
  endtask

  task automatic test_abort();
    abort_case(8'h20, 8'hFF, 1, "abort_early");
    abort_case(8'h21, 8'h5A, 3, "abort_at_zero");
  endtask

  task automatic test_back_to_back();
    int lat1, lat2; logic err, ra1, ra2, ee; logic [7:0] rd, er;
    xfer(0, 1'b1, 8'h01, 8'h11, lat1, err, rd, ra1);
    model_xfer(0, 1'b1, 8'h01, 8'h11, ee, er);
    xfer(0, 1'b0, 8'h01, 8'h00, lat2, err, rd, ra2);
    model_xfer(0, 1'b0, 8'h01, 8'h00, ee, er);
    tests++;
    if (lat1 !== 2 || lat2 !== 2 || rd !== 8'h11 || ra1 !== 1'b0 || ra2 !== 1'b0) begin
      fails++;
      $display("FAIL b2b: got lat1=%0d lat2=%0d prdata=%h rn1=%b rn2=%b, want 2 2 11 0 0",
               lat1, lat2, rd, ra1, ra2);
    end
  endtask

  task automatic test_random();
    int lat, gap, sel; logic err, ra, ee, wr; logic [7:0] rd, er, a, d;
    for (int n = 0; n < 180; n++) begin
      int i;
      i   = n % 3;
      wr  = 1'($urandom_range(0, 1));
      d   = 8'($urandom);
      sel = $urandom_range(0, 7);
      case (sel)
        0:       a = 8'h00;
        1:       a = 8'(depth_m[i] - 1);
        2:       a = 8'(depth_m[i] % 256);
        3:       a = 8'hFF;
        default: a = 8'($urandom_range(0, 15));
      endcase
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) @(negedge pclk);
      xfer(i, wr, a, d, lat, err, rd, ra);
      model_xfer(i, wr, a, d, ee, er);
      tests++;
      if (lat !== wait_m[i] + 2 || ra !== 1'b0) begin
        fails++;
        $display("FAIL rnd_lat[%0d]: got lat=%0d ready_next=%b, want lat=%0d ready_next=0", n, lat, ra, wait_m[i] + 2);
      end
      tests++;
      if (err !== ee) begin
        fails++;
        $display("FAIL rnd_err[%0d]: got pslverr=%b, want %b (inst %0d addr %h)", n, err, ee, i, a);
      end
      tests++;
      if (rd !== er) begin
        fails++;
        $display("FAIL rnd_rd[%0d]: got prdata=%h, want %h (inst %0d addr %h wr %b)", n, rd, er, i, a, wr);
      end
    end
  endtask

  task automatic test_reset_mid();
    int lat; logic err, ra, ee; logic [7:0] rd, er;
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 8'h05; pwdata[1] = 8'h77;
    @(negedge pclk); penable[1] = 1'b1;
    @(negedge pclk);
    #2 presetn = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      tests++;
      if ({prdata[i], pready[i], pslverr[i], stage[i]} !== 12'h000) begin
        fails++;
        $display("FAIL mid_reset[%0d]: got prdata=%h pready=%b pslverr=%b stage=%b, want all zero",
                 i, prdata[i], pready[i], pslverr[i], stage[i]);
      end
    end
    model_clear();
    psel[1] = 1'b0; penable[1] = 1'b0;
    @(negedge pclk);
    presetn = 1'b1;
    @(negedge pclk);
    xfer(1, 1'b0, 8'h05, 8'h00, lat, err, rd, ra);
    model_xfer(1, 1'b0, 8'h05, 8'h00, ee, er);
    tests++;
    if (lat !== 5 || rd !== 8'h00) begin
      fails++;
      $display("FAIL mid_reset_rd: got lat=%0d prdata=%h, want lat=5 prdata=00", lat, rd);
    end
    xfer(0, 1'b0, 8'h10, 8'h00, lat, err, rd, ra);
    model_xfer(0, 1'b0, 8'h10, 8'h00, ee, er);
    tests++;
    if (rd !== er) begin
      fails++;
      $display("FAIL mid_reset_clear: got prdata=%h, want %h", rd, er);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      psel[i] = 1'b0; penable[i] = 1'b0; pwrite[i] = 1'b0; paddr[i] = 8'h00; pwdata[i] = 8'h00;
    end
    presetn = 1'b1;
    @(negedge pclk);
    test_reset();
    test_write_read();
    test_wait_states();
    test_out_of_range();
    test_abort();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
